ped_signal_bank: RTL
====================

Name: ped_signal_bank

Overview:
Parametrised pedestrian-signal controller driving NUM_XING independent crossings, each with a hand LED, a person LED and a clearance countdown. Each crossing latches button requests and raises a request to the vehicle traffic FSM. It runs WALK then flashing-hand CLEARANCE only while granted, and pulses done when it returns to DONT_WALK. It sits between the intersection FSM and the LED/display drivers. It has its own timers and one shared blink generator.

Parameters:
NUM_XING, 4, number of crossings (channels), 1..16
CNT_W, 8, width of phase timers and countdown outputs
WALK_CYCLES, 100, WALK duration in clock cycles, 1..2^CNT_W
CLEAR_CYCLES, 50, CLEARANCE duration in cycles, 1..2^CNT_W-1
BLINK_HALF, 25, cycles per half-period of the flashing hand, >=1

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
button  in  NUM_XING  per-crossing push-button, already debounced and synchronised, level
walk_grant  in  NUM_XING  per-crossing permission from the vehicle FSM, level
ped_req  out  NUM_XING  request pending, to the vehicle FSM
ped_busy  out  NUM_XING  crossing in WALK or CLEARANCE
done  out  NUM_XING  1-cycle pulse on return to DONT_WALK
hand_led  out  NUM_XING  don't-walk hand LED
person_led  out  NUM_XING  walk person LED
countdown  out  NUM_XING*CNT_W  per-crossing remaining clearance cycles; channel i at bits [i*CNT_W +: CNT_W]

Behaviour:
- All outputs are a decode of registered state only. There is no combinational input-to-output path.
- Reset, in any state and mid-phase: every channel goes to DONT_WALK, pending=0, timer=0, blink counter=0, blink phase=0. Outputs: hand_led=all 1, person_led=0, ped_req=0, ped_busy=0, done=0, countdown=0.
- Per-channel FSM states: DONT_WALK, WALK, CLEAR.
- Request latch:
  - button=1 in DONT_WALK or CLEAR sets pending; ped_req follows on the next cycle.
  - button in WALK is ignored.
  - Pending clears on the edge that enters WALK.
  - If button and the WALK entry happen on the same edge, entry wins and pending ends at 0.
- DONT_WALK -> WALK when pending=1 && walk_grant=1 on the same edge.
  - On entry the timer loads WALK_CYCLES-1.
  - The grant is ignored while pending=0.
- WALK:
  - Timer decrements each cycle.
  - When timer==0, go to CLEAR. WALK therefore lasts exactly WALK_CYCLES cycles.
  - If walk_grant drops during WALK, go to CLEAR on the next edge (early termination).
  - On CLEAR entry the timer loads CLEAR_CYCLES-1.
- CLEAR:
  - Timer decrements each cycle; at timer==0 go to DONT_WALK. CLEAR lasts exactly CLEAR_CYCLES cycles.
  - walk_grant is ignored in CLEAR.
  - A new button press is latched for the next cycle.
- done is 1 only on the first cycle after CLEAR -> DONT_WALK.
- A channel with pending=1 and grant=1 re-enters WALK on the edge after done. DONT_WALK is held for a minimum of 1 cycle.
- LED decode:
  - DONT_WALK: hand=1, person=0.
  - WALK: hand=0, person=1.
  - CLEAR: person=0, hand=blink_phase.
- Countdown: in CLEAR it is timer+1 (CLEAR_CYCLES down to 1); otherwise 0.
- ped_busy = (state != DONT_WALK).
- Blink generator:
  - Free-running, shared by all channels, not restarted by channel events.
  - Counter runs 0..BLINK_HALF-1; blink_phase toggles on the edge where the counter wraps.
  - After reset, phase=0 for cycles 0..BLINK_HALF-1, then 1 for the next BLINK_HALF cycles, and so on.
- Channels are fully independent. Simultaneous grants on several channels are all honoured.
- Timers never underflow: the timer is not decremented in DONT_WALK, where it holds 0.

Decomposition:
- Package ped_pkg holds the state encoding enum (DONT_WALK=2'd0, WALK=2'd1, CLEAR=2'd2) and the CNT_W default.
- Sub-module ped_channel (one FSM + timer + pending latch) is instantiated NUM_XING times via generate.
- Shared blink logic is a separate sub-module, blink_gen (parameter BLINK_HALF; output phase).

Test Plan:
All scenarios use NUM_XING=2, CNT_W=8, WALK_CYCLES=5, CLEAR_CYCLES=4, BLINK_HALF=2.
1. Reset, then idle 10 cycles -> hand_led=2'b11, person_led=0, ped_req=0, countdown=0, done never asserted.
2. Pulse button[0] at cycle 3, hold grant[0]=1 from cycle 6:
   - ped_req[0] is 1 from cycle 4.
   - WALK on cycles 7-11 with person_led[0]=1 and ped_req[0]=0.
   - CLEAR on cycles 12-15 with countdown 4,3,2,1 and hand_led[0] equal to blink_phase.
   - done[0]=1 on cycle 16 only.
3. Grant[1]=1 for 20 cycles with no button -> channel 1 stays DONT_WALK; ped_busy[1]=0.
4. Channel 0 in WALK, drop grant[0] on the 2nd WALK cycle -> CLEAR on the next cycle with countdown=4, lasting 4 cycles.
5. Button[0] during CLEAR, grant held -> ped_req[0]=1; done pulses, then WALK re-entered the cycle after done.
6. Assert reset on the 2nd CLEAR cycle -> next cycle: all channels in DONT_WALK, countdown=0, ped_req=0, done=0, blink counter restarted.

Source files
------------

// File: rtl/ped_pkg.sv
// Shared types and defaults for the pedestrian signal bank.
// Channel state encoding is fixed so that LED drivers and debug tooling can decode it directly.
package ped_pkg;

  typedef enum logic [1:0] {
    DONT_WALK = 2'd0,
    WALK      = 2'd1,
    CLEAR     = 2'd2
  } pedState_t;

  localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/blink_gen.sv
// Free-running blink generator shared by all crossings.
// The phase flips every BLINK_HALF cycles and is never restarted by channel activity.
module blink_gen #(
  parameter int BLINK_HALF = 25
) (
  input  logic clk,
  input  logic reset,
  output logic phase
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] blinkCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      blinkCnt <= '0;
      phase    <= 1'b0;
    end else if (blinkCnt == LAST) begin
      blinkCnt <= '0;
      phase    <= ~phase;
    end else begin
      blinkCnt <= blinkCnt + BW'(1);
    end
  end

endmodule

// File: rtl/ped_channel.sv
// One pedestrian crossing: request latch, phase timer and WALK/CLEAR sequencing FSM.
//   state     | meaning
//   DONT_WALK | idle, hand lit, waiting for pending request plus grant
//   WALK      | person lit, timer counts WALK_CYCLES down, ends early on grant loss
//   CLEAR     | flashing hand, timer counts CLEAR_CYCLES down, grant ignored
module ped_channel import ped_pkg::*; #(
  parameter int CNT_W        = CNT_W_DEFAULT,
  parameter int WALK_CYCLES  = 100,
  parameter int CLEAR_CYCLES = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             button,
  input  logic             walkGrant,
  input  logic             blinkPhase,
  output logic             pedReq,
  output logic             pedBusy,
  output logic             done,
  output logic             handLed,
  output logic             personLed,
  output logic [CNT_W-1:0] countdown
);

  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

  pedState_t        state;
  logic [CNT_W-1:0] timer;
  logic             pending;
  logic             doneReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= DONT_WALK;
      timer   <= '0;
      pending <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      unique case (state)
        DONT_WALK: begin
          // Entering WALK consumes the request, even if the button is still held.
          if (pending && walkGrant) begin
            state   <= WALK;
            timer   <= WALK_LOAD;
            pending <= 1'b0;
          end else if (button) begin
            pending <= 1'b1;
          end
        end
        WALK: begin
          if ((timer == '0) || !walkGrant) begin
            state <= CLEAR;
            timer <= CLEAR_LOAD;
          end else begin
            timer <= timer - CNT_W'(1);
          end
        end
        CLEAR: begin
          if (button) pending <= 1'b1;
          if (timer == '0) begin
            state   <= DONT_WALK;
            doneReg <= 1'b1;
          end else begin
            timer <= timer - CNT_W'(1);
          end
        end
        default: begin
          state <= DONT_WALK;
          timer <= '0;
        end
      endcase
    end
  end

  always_comb begin
    pedReq    = pending;
    pedBusy   = (state != DONT_WALK);
    done      = doneReg;
    handLed   = 1'b1;
    personLed = 1'b0;
    countdown = '0;
    case (state)
      WALK: begin
        handLed   = 1'b0;
        personLed = 1'b1;
      end
      CLEAR: begin
        handLed   = blinkPhase;
        countdown = timer + CNT_W'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ped_signal_bank.sv
// Bank of independent pedestrian crossings sharing one blink generator.
// Sits between the intersection FSM (request/grant) and the LED/countdown drivers.
module ped_signal_bank import ped_pkg::*; #(
  parameter int NUM_XING     = 4,
  parameter int CNT_W        = CNT_W_DEFAULT,
  parameter int WALK_CYCLES  = 100,
  parameter int CLEAR_CYCLES = 50,
  parameter int BLINK_HALF   = 25
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_XING-1:0]       button,
  input  logic [NUM_XING-1:0]       walk_grant,
  output logic [NUM_XING-1:0]       ped_req,
  output logic [NUM_XING-1:0]       ped_busy,
  output logic [NUM_XING-1:0]       done,
  output logic [NUM_XING-1:0]       hand_led,
  output logic [NUM_XING-1:0]       person_led,
  output logic [NUM_XING*CNT_W-1:0] countdown
);

  logic blinkPhase;

  blink_gen #(
    .BLINK_HALF(BLINK_HALF)
  ) uBlink (
    .clk  (clk),
    .reset(reset),
    .phase(blinkPhase)
  );

  for (genvar i = 0; i < NUM_XING; i++) begin : gChan
    ped_channel #(
      .CNT_W       (CNT_W),
      .WALK_CYCLES (WALK_CYCLES),
      .CLEAR_CYCLES(CLEAR_CYCLES)
    ) uChan (
      .clk       (clk),
      .reset     (reset),
      .button    (button[i]),
      .walkGrant (walk_grant[i]),
      .blinkPhase(blinkPhase),
      .pedReq    (ped_req[i]),
      .pedBusy   (ped_busy[i]),
      .done      (done[i]),
      .handLed   (hand_led[i]),
      .personLed (person_led[i]),
      .countdown (countdown[i*CNT_W +: CNT_W])
    );
  end

endmodule
